// File: rtl/pipelined_carry_skip_adder.sv
// rtl/pipelined_carry_skip_adder.sv - carry-skip adder/subtractor, one pipeline stage per block
// Block k resolves its sum bits and carry-out in stage k; operands travel alongside.
module pipelined_carry_skip_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4,
  localparam int STAGES = WIDTH / BLOCK
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              c_in,
  input  logic              sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  sum,
  output logic              c_out,
  output logic              ovf,
  output logic [STAGES-1:0] skip_mask
);

  if ((BLOCK < 1) || (BLOCK > WIDTH) || ((WIDTH % BLOCK) != 0)) begin : g_param_check
    $error("WIDTH must be a non-zero integer multiple of BLOCK");
  end

  logic              adv;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [STAGES-1:0] m_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] v_q;
  logic              msb_carry_q;

  // A stalled output freezes every stage, so bubbles and data never slip past each other.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0]  a_i, b_i, s_i, s_o;
    logic [STAGES-1:0] m_i, m_o;
    logic              c_i, v_i, blk_p, c_o;
    logic [BLOCK:0]    rc;
    logic [BLOCK-1:0]  p, s_blk;

    if (k == 0) begin : g_head
      assign a_i = a;
      assign b_i = sub ? ~b : b;
      assign c_i = sub | c_in;
      assign s_i = '0;
      assign m_i = '0;
      assign v_i = in_valid;
    end else begin : g_body
      assign a_i = a_q[k-1];
      assign b_i = b_q[k-1];
      assign c_i = c_q[k-1];
      assign s_i = s_q[k-1];
      assign m_i = m_q[k-1];
      assign v_i = v_q[k-1];
    end

    always_comb begin
      rc    = '0;
      p     = '0;
      s_blk = '0;
      rc[0] = c_i;
      for (int i = 0; i < BLOCK; i++) begin
        p[i]     = a_i[k*BLOCK+i] ^ b_i[k*BLOCK+i];
        s_blk[i] = p[i] ^ rc[i];
        rc[i+1]  = (a_i[k*BLOCK+i] & b_i[k*BLOCK+i]) | (p[i] & rc[i]);
      end
    end

    // Full-propagate blocks forward their carry-in directly instead of the ripple result.
    assign blk_p = &p;
    assign c_o   = blk_p ? c_i : rc[BLOCK];
    assign s_o   = s_i | (WIDTH'(s_blk) << (k*BLOCK));
    assign m_o   = m_i | (STAGES'(blk_p) << k);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        m_q[k] <= '0;
      end else if (adv) begin
        v_q[k] <= v_i;
        a_q[k] <= a_i;
        b_q[k] <= b_i;
        s_q[k] <= s_o;
        c_q[k] <= c_o;
        m_q[k] <= m_o;
      end
    end

    if (k == STAGES-1) begin : g_tail
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   msb_carry_q <= 1'b0;
        else if (adv) msb_carry_q <= rc[BLOCK-1];
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign c_out     = c_q[STAGES-1];
  assign ovf       = msb_carry_q ^ c_q[STAGES-1];
  assign skip_mask = m_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_carry_skip_adder.sv
// tb/tb_pipelined_carry_skip_adder.sv - scoreboard bench for a 16/4 and an 8/8 instance
module tb_pipelined_carry_skip_adder;

  typedef struct {
    logic [15:0] sum;
    logic        c_out;
    logic        ovf;
    logic [3:0]  mask;
    int          cyc;
    int          frz;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v0, ci0, sub0, ordy0, irdy0, ov0, co0, of0;
  logic [15:0] a0, b0, sum0;
  logic [3:0]  m0;
  logic        v1, ci1, sub1, ordy1, irdy1, ov1, co1, of1;
  logic [7:0]  a1, b1, sum1;
  logic [0:0]  m1;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   frz0 = 0;
  int   frz1 = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic dir0 = 1'b0;
  exp_t dexp0;

  pipelined_carry_skip_adder #(.WIDTH(16), .BLOCK(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(irdy0), .a(a0), .b(b0),
    .c_in(ci0), .sub(sub0), .out_valid(ov0), .out_ready(ordy0), .sum(sum0),
    .c_out(co0), .ovf(of0), .skip_mask(m0));

  pipelined_carry_skip_adder #(.WIDTH(8), .BLOCK(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(irdy1), .a(a1), .b(b1),
    .c_in(ci1), .sub(sub1), .out_valid(ov1), .out_ready(ordy1), .sum(sum1),
    .c_out(co1), .ovf(of1), .skip_mask(m1));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the effective operands.
  function automatic exp_t model(input int w, input int blk, input logic [15:0] a,
                                 input logic [15:0] b, input logic c, input logic s);
    exp_t        e;
    int unsigned m, bb, cc, full, low, p, bm;
    m      = (32'd1 << w) - 1;
    bb     = (s ? ~{16'h0, b} : {16'h0, b}) & m;
    cc     = s ? 1 : 32'(c);
    full   = 32'(a) + bb + cc;
    e.sum  = 16'(full & m);
    e.c_out = 1'((full >> w) & 1);
    low    = (32'(a) & (m >> 1)) + (bb & (m >> 1)) + cc;
    e.ovf  = 1'((low >> (w - 1)) & 1) ^ e.c_out;
    p      = 32'(a) ^ bb;
    bm     = (32'd1 << blk) - 1;
    e.mask = '0;
    for (int k = 0; k < w / blk; k++) e.mask[k] = (((p >> (k * blk)) & bm) == bm);
    e.cyc = 0;
    e.frz = 0;
    return e;
  endfunction

  logic        held0 = 1'b0;
  logic [22:0] snap0;
  always @(negedge clk) begin : mon0
    exp_t e;
    if (!rst_n) held0 = 1'b0;
    else begin
      chk("in_ready0_rule", 32'(irdy0), 32'(!ov0 || ordy0));
      if (held0) chk("hold0", 32'({ov0, sum0, co0, of0, m0}), 32'(snap0));
      if (ov0 && ordy0) begin
        if (q0.size() == 0) chk("spurious_out0", 32'(ov0), 32'd0);
        else begin
          e = q0.pop_front();
          chk("sum0", 32'(sum0), 32'(e.sum));
          chk("c_out0", 32'(co0), 32'(e.c_out));
          chk("ovf0", 32'(of0), 32'(e.ovf));
          chk("skip_mask0", 32'(m0), 32'(e.mask));
          chk("latency0", 32'(cyc), 32'(e.cyc + 3 + (frz0 - e.frz)));
        end
      end
      held0 = ov0 && !ordy0;
      snap0 = {ov0, sum0, co0, of0, m0};
      if (held0) frz0++;
      if (v0 && irdy0) begin
        e = dir0 ? dexp0 : model(16, 4, a0, b0, ci0, sub0);
        e.cyc = cyc + 1;
        e.frz = frz0;
        q0.push_back(e);
      end
    end
  end

  logic        held1 = 1'b0;
  logic [11:0] snap1;
  always @(negedge clk) begin : mon1
    exp_t e;
    if (!rst_n) held1 = 1'b0;
    else begin
      chk("in_ready1_rule", 32'(irdy1), 32'(!ov1 || ordy1));
      if (held1) chk("hold1", 32'({ov1, sum1, co1, of1, m1}), 32'(snap1));
      if (ov1 && ordy1) begin
        if (q1.size() == 0) chk("spurious_out1", 32'(ov1), 32'd0);
        else begin
          e = q1.pop_front();
          chk("sum1", 32'(sum1), 32'(e.sum));
          chk("c_out1", 32'(co1), 32'(e.c_out));
          chk("ovf1", 32'(of1), 32'(e.ovf));
          chk("skip_mask1", 32'(m1), 32'(e.mask));
          chk("latency1", 32'(cyc), 32'(e.cyc + (frz1 - e.frz)));
        end
      end
      held1 = ov1 && !ordy1;
      snap1 = {ov1, sum1, co1, of1, m1};
      if (held1) frz1++;
      if (v1 && irdy1) begin
        e = model(8, 8, {8'h0, a1}, {8'h0, b1}, ci1, sub1);
        e.cyc = cyc + 1;
        e.frz = frz1;
        q1.push_back(e);
      end
    end
  end

  task automatic present0(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
    v0 = 1'b1; a0 = a; b0 = b; ci0 = c; sub0 = s; ordy0 = 1'b1;
    for (int g = 0; g < 50; g++) begin
      @(negedge clk);
      if (irdy0) begin
        @(posedge clk); #1;
        v0 = 1'b0; dir0 = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("accept_timeout0", 32'(irdy0), 32'd1);
    v0 = 1'b0; dir0 = 1'b0;
  endtask

  task automatic send_dir(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s,
                          input logic [15:0] es, input logic eco, input logic eov, input logic [3:0] em);
    dexp0.sum = es; dexp0.c_out = eco; dexp0.ovf = eov; dexp0.mask = em;
    dir0 = 1'b1;
    present0(a, b, c, s);
  endtask

  task automatic run(input int n0, input int n1, input bit burst);
    int s0 = 0;
    int s1 = 0;
    int c = 0;
    bit acc0, acc1;
    while ((s0 < n0 || s1 < n1) && c < 5000) begin
      if (!v0 && s0 < n0 && (burst || $urandom_range(3) != 0)) begin
        v0 = 1'b1; a0 = 16'($urandom); b0 = 16'($urandom); ci0 = 1'($urandom); sub0 = 1'($urandom);
      end
      if (!v1 && s1 < n1 && $urandom_range(3) != 0) begin
        v1 = 1'b1; a1 = 8'($urandom); b1 = 8'($urandom); ci1 = 1'($urandom); sub1 = 1'($urandom);
      end
      ordy0 = burst ? !(c >= 4 && c < 7) : ($urandom_range(3) != 0);
      ordy1 = $urandom_range(3) != 0;
      @(negedge clk);
      acc0 = v0 && irdy0;
      acc1 = v1 && irdy1;
      @(posedge clk); #1;
      c++;
      if (acc0) begin v0 = 1'b0; s0++; end
      if (acc1) begin v1 = 1'b0; s1++; end
    end
    if (c >= 5000) chk("run_timeout", 32'(c), 32'd0);
    v0 = 1'b0; v1 = 1'b0; ordy0 = 1'b1; ordy1 = 1'b1;
  endtask

  task automatic drain();
    v0 = 1'b0; v1 = 1'b0; ordy0 = 1'b1; ordy1 = 1'b1;
    for (int g = 0; g < 100 && (q0.size() != 0 || q1.size() != 0); g++) begin
      @(posedge clk); #1;
    end
    repeat (6) @(posedge clk);
    #1;
    chk("drain_q0", 32'(q0.size()), 32'd0);
    chk("drain_q1", 32'(q1.size()), 32'd0);
  endtask

  initial begin
    v0 = 0; a0 = 0; b0 = 0; ci0 = 0; sub0 = 0; ordy0 = 1;
    v1 = 0; a1 = 0; b1 = 0; ci1 = 0; sub1 = 0; ordy1 = 1;
    repeat (3) @(negedge clk);
    chk("reset_out_valid0", 32'(ov0), 32'd0);
    chk("reset_sum0", 32'(sum0), 32'd0);
    chk("reset_flags0", 32'({co0, of0, m0}), 32'd0);
    chk("reset_in_ready0", 32'(irdy0), 32'd1);
    chk("reset_out_valid1", 32'(ov1), 32'd0);
    chk("reset_in_ready1", 32'(irdy1), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    send_dir(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 4'b0010);
    send_dir(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b1111);
    send_dir(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 4'b0110);
    send_dir(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b0110);
    send_dir(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'b0000);
    drain();

    run(8, 0, 1'b1);
    drain();
    run(150, 150, 1'b0);
    drain();

    present0(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    @(posedge clk); #1;
    present0(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    present0(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    chk("inflight_before_reset", 32'(ov0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_out_valid", 32'(ov0), 32'd0);
    chk("reset_mid_fields", 32'({sum0, co0, of0, m0}), 32'd0);
    chk("reset_mid_in_ready", 32'(irdy0), 32'd1);
    q0.delete();
    q1.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_reset_idle", 32'(ov0), 32'd0);
    end
    @(posedge clk); #1;
    present0(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
